// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I branch encodings and instruction constants
package rv32i_types_pkg;

  // Encodings follow the branch funct3 field; 3'b010/3'b011 are unused.
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_t;

  // Fall-through step for a non-compressed instruction.
  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/branch_res_pipe_if.sv
// rtl/branch_res_pipe_if.sv - request/result/counter bundle for the branch resolution unit
interface branch_res_pipe_if
  import rv32i_types_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  pc;
  logic [11:0]      imm_b;
  branch_t          branch_type;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_addr;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;

  logic [CNT_W-1:0] cnt_branches;
  logic [CNT_W-1:0] cnt_mispredicts;
  logic             cnt_clear;

  // Resolution unit side.
  modport slave (
    input  in_valid, rs1_data, rs2_data, pc, imm_b, branch_type,
           pred_taken, pred_target, flush, out_ready, cnt_clear,
    output in_ready, out_valid, branch_taken, branch_addr, mispredict,
           redirect_pc, cnt_branches, cnt_mispredicts
  );

  // Issue/consumer side.
  modport master (
    output in_valid, rs1_data, rs2_data, pc, imm_b, branch_type,
           pred_taken, pred_target, flush, out_ready, cnt_clear,
    input  in_ready, out_valid, branch_taken, branch_addr, mispredict,
           redirect_pc, cnt_branches, cnt_mispredicts
  );

endinterface

// File: rtl/branch_res_pipe_cmp.sv
// rtl/branch_res_pipe_cmp.sv - combinational branch condition evaluator
module branch_cmp
  import rv32i_types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  branch_t         branch_type,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // Select the condition; unused encodings resolve as not taken.
  always_comb begin
    taken = 1'b0;
    case (branch_type)
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt_s;
      BGE:     taken = !lt_s;
      BLTU:    taken = lt_u;
      BGEU:    taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_res_pipe.sv
// rtl/branch_res_pipe.sv - registered branch resolution with redirect and event counters
module branch_res_pipe
  import rv32i_types_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic           CLK,
  input  logic           nRST,
  branch_res_pipe_if.slave bus
);

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic  out_valid_q, out_valid_d;
  logic  taken_q, taken_d;
  logic  mispredict_q, mispredict_d;
  word_t branch_addr_q, branch_addr_d;
  word_t redirect_pc_q, redirect_pc_d;
  cnt_t  cnt_br_q, cnt_br_d;
  cnt_t  cnt_mis_q, cnt_mis_d;

  logic  taken_c;
  logic  accept;
  logic  out_hs;
  word_t target_c;
  word_t fallthru_c;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1         (bus.rs1_data),
    .rs2         (bus.rs2_data),
    .branch_type (bus.branch_type),
    .taken       (taken_c)
  );

  // Single output register with no skid: room exists when empty or draining.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  // A flushed result is never delivered, so it never counts.
  assign out_hs       = out_valid_q && bus.out_ready && !bus.flush;

  // Offset {imm_b,0} is sign-extended from bit 12; sums wrap modulo 2^XLEN.
  assign target_c   = bus.pc + word_t'($signed({bus.imm_b, 1'b0}));
  assign fallthru_c = bus.pc + word_t'(INSN_BYTES);

  // Next output register contents: load on accept, clear valid on flush or drain.
  always_comb begin
    out_valid_d   = out_valid_q;
    taken_d       = taken_q;
    mispredict_d  = mispredict_q;
    branch_addr_d = branch_addr_q;
    redirect_pc_d = redirect_pc_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      taken_d       = taken_c;
      branch_addr_d = target_c;
      redirect_pc_d = taken_c ? target_c : fallthru_c;
      mispredict_d  = (taken_c != bus.pred_taken) ||
                      (taken_c && bus.pred_taken && (bus.pred_target != target_c));
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating event counters; clear beats a same-cycle increment.
  always_comb begin
    cnt_br_d  = cnt_br_q;
    cnt_mis_d = cnt_mis_q;
    if (bus.cnt_clear) begin
      cnt_br_d  = '0;
      cnt_mis_d = '0;
    end else if (out_hs) begin
      if (cnt_br_q != '1) begin
        cnt_br_d = cnt_br_q + cnt_t'(1);
      end
      if (mispredict_q && (cnt_mis_q != '1)) begin
        cnt_mis_d = cnt_mis_q + cnt_t'(1);
      end
    end
  end

  // Result register; reset discards any held result.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      branch_addr_q <= '0;
      redirect_pc_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      branch_addr_q <= branch_addr_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Performance counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_br_q  <= '0;
      cnt_mis_q <= '0;
    end else begin
      cnt_br_q  <= cnt_br_d;
      cnt_mis_q <= cnt_mis_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.branch_taken    = taken_q;
  assign bus.mispredict      = mispredict_q;
  assign bus.branch_addr     = branch_addr_q;
  assign bus.redirect_pc     = redirect_pc_q;
  assign bus.cnt_branches    = cnt_br_q;
  assign bus.cnt_mispredicts = cnt_mis_q;

endmodule

// File: tb/tb_branch_res_pipe.sv
// tb/tb_branch_res_pipe.sv - scoreboard bench for branch_res_pipe
module tb_branch_res_pipe;
  import rv32i_types_pkg::*;

  localparam logic [3:0] CNT_MAX = 4'hF;

  typedef struct {
    logic        taken;
    logic [31:0] addr;
    logic [31:0] red;
    logic        mis;
  } exp_t;

  logic clk;
  logic nrst;
  exp_t sb[$];
  int   n_pass;
  int   n_total;
  logic [3:0] exp_br;
  logic [3:0] exp_mis;

  branch_res_pipe_if #(.XLEN(32), .CNT_W(4)) bif ();

  branch_res_pipe #(.XLEN(32), .CNT_W(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input branch_t bt, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [11:0] imm, input logic pt,
                       input logic [31:0] ptgt);
    bif.in_valid    = 1'b1;
    bif.branch_type = bt;
    bif.rs1_data    = a;
    bif.rs2_data    = b;
    bif.pc          = p;
    bif.imm_b       = imm;
    bif.pred_taken  = pt;
    bif.pred_target = ptgt;
  endtask

  task automatic issue(input branch_t bt, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [11:0] imm, input logic pt,
                       input logic [31:0] ptgt, input logic et, input logic [31:0] ea,
                       input logic [31:0] er, input logic em);
    exp_t e;
    bit   done;
    int   n;
    drive(bt, a, b, p, imm, pt, ptgt);
    e = '{taken: et, addr: ea, red: er, mis: em};
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (bif.in_ready && !bif.flush) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bif.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares presented results against the queue front and tracks counters.
  initial begin
    exp_t e;
    bit   hs;
    forever begin
      @(negedge clk);
      hs = 1'b0;
      if (!nrst) begin
        exp_br  = '0;
        exp_mis = '0;
      end else begin
        chk("cnt_branches", bif.cnt_branches, exp_br);
        chk("cnt_mispredicts", bif.cnt_mispredicts, exp_mis);
        if (bif.out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            e = sb[0];
            chk("branch_taken", bif.branch_taken, e.taken);
            chk("branch_addr", bif.branch_addr, e.addr);
            chk("redirect_pc", bif.redirect_pc, e.red);
            chk("mispredict", bif.mispredict, e.mis);
            if (bif.out_ready && !bif.flush) begin
              void'(sb.pop_front());
              hs = 1'b1;
            end
          end
        end
        if (bif.cnt_clear) begin
          exp_br  = '0;
          exp_mis = '0;
        end else if (hs) begin
          if (exp_br != CNT_MAX) exp_br = exp_br + 4'd1;
          if (e.mis && exp_mis != CNT_MAX) exp_mis = exp_mis + 4'd1;
        end
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    exp_br  = '0;
    exp_mis = '0;
    nrst = 1'b0;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    bif.flush = 1'b0;
    bif.cnt_clear = 1'b0;
    drive(BEQ, 32'd0, 32'd0, 32'd0, 12'd0, 1'b0, 32'd0);
    bif.in_valid = 1'b0;

    #2;
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_in_ready", bif.in_ready, 1);
    chk("rst_taken", bif.branch_taken, 0);
    chk("rst_mispredict", bif.mispredict, 0);
    chk("rst_branch_addr", bif.branch_addr, 0);
    chk("rst_redirect_pc", bif.redirect_pc, 0);
    chk("rst_cnt_branches", bif.cnt_branches, 0);
    chk("rst_cnt_mispredicts", bif.cnt_mispredicts, 0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    chk("post_rst_in_ready", bif.in_ready, 1);

    // BEQ taken, correctly predicted; one-cycle latency, then one count.
    issue(BEQ, 32'h5, 32'h5, 32'h100, 12'h008, 1'b1, 32'h110, 1'b1, 32'h110, 32'h110, 1'b0);
    chk("latency_out_valid", bif.out_valid, 1);
    idle();
    chk("first_cnt_branches", bif.cnt_branches, 1);
    chk("first_out_valid_low", bif.out_valid, 0);

    // Back-to-back directed vectors.
    issue(BLT,  32'hFFFFFFFF, 32'h1, 32'h200, 12'h010, 1'b1, 32'h220, 1'b1, 32'h220, 32'h220, 1'b0);
    issue(BLTU, 32'hFFFFFFFF, 32'h1, 32'h200, 12'h010, 1'b1, 32'h220, 1'b0, 32'h220, 32'h204, 1'b1);
    issue(BNE,  32'h1, 32'h2, 32'hFFFFFFFC, 12'h002, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
    issue(BNE,  32'h3, 32'h3, 32'h0, 12'hFFE, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFC, 32'h4, 1'b0);
    issue(BGE,  32'h80000000, 32'h1, 32'h500, 12'h000, 1'b0, 32'h0, 1'b0, 32'h500, 32'h504, 1'b0);
    issue(branch_t'(3'b010), 32'h0, 32'h0, 32'h600, 12'h001, 1'b1, 32'h602, 1'b0, 32'h602, 32'h604, 1'b1);
    issue(BEQ,  32'h1, 32'h2, 32'hFFFFFFFC, 12'h010, 1'b0, 32'h0, 1'b0, 32'h1C, 32'h0, 1'b0);
    idle();

    // Back-pressure: result held three cycles, next request waits, then both move together.
    bif.out_ready = 1'b0;
    issue(BGE, 32'h7, 32'h7, 32'h300, 12'h004, 1'b1, 32'h300, 1'b1, 32'h308, 32'h308, 1'b1);
    drive(BGEU, 32'h1, 32'hFFFFFFFF, 32'h400, 12'h000, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", bif.in_ready, 0);
      chk("bp_out_valid", bif.out_valid, 1);
      @(posedge clk);
      #1;
    end
    bif.out_ready = 1'b1;
    issue(BGEU, 32'h1, 32'hFFFFFFFF, 32'h400, 12'h000, 1'b0, 32'h0, 1'b0, 32'h400, 32'h404, 1'b0);
    idle();

    // Flush while out_valid && out_ready: no delivery, no count, no accept.
    issue(BEQ, 32'h5, 32'h5, 32'h100, 12'h008, 1'b1, 32'h110, 1'b1, 32'h110, 32'h110, 1'b0);
    bif.flush = 1'b1;
    drive(BLT, 32'hFFFFFFFF, 32'h1, 32'h200, 12'h010, 1'b1, 32'h220);
    @(posedge clk);
    #1;
    chk("flush_out_valid", bif.out_valid, 0);
    if (sb.size() > 0) void'(sb.pop_front());
    bif.flush = 1'b0;
    idle();
    chk("flush_no_accept", bif.out_valid, 0);

    // Asynchronous reset with a held result discards it.
    bif.out_ready = 1'b0;
    issue(BNE, 32'h1, 32'h2, 32'h700, 12'h000, 1'b0, 32'h0, 1'b1, 32'h700, 32'h700, 1'b1);
    bif.in_valid = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("midrst_out_valid", bif.out_valid, 0);
    chk("midrst_in_ready", bif.in_ready, 1);
    chk("midrst_cnt_branches", bif.cnt_branches, 0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk);
    #1;
    nrst = 1'b1;
    bif.out_ready = 1'b1;

    // Saturation: 16 mispredicted handshakes pin both 4-bit counters at 0xF.
    for (int i = 0; i < 16; i++) begin
      issue(BEQ, 32'h1, 32'h2, 32'h200, 12'h000, 1'b1, 32'h200, 1'b0, 32'h200, 32'h204, 1'b1);
    end
    idle();
    chk("sat_cnt_branches", bif.cnt_branches, 4'hF);
    chk("sat_cnt_mispredicts", bif.cnt_mispredicts, 4'hF);

    // Clear coincident with a handshake wins.
    issue(BEQ, 32'h5, 32'h5, 32'h100, 12'h008, 1'b1, 32'h110, 1'b1, 32'h110, 32'h110, 1'b0);
    bif.in_valid = 1'b0;
    bif.cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    bif.cnt_clear = 1'b0;
    chk("clr_cnt_branches", bif.cnt_branches, 0);
    chk("clr_cnt_mispredicts", bif.cnt_mispredicts, 0);

    idle();
    idle();
    chk("scoreboard_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
